shift_right_seq: RTL and testbench

//  Sequential sign-magnitude fixed-point right shifter; the inverse of the

---
 rtl/shift_right_seq_if.sv | 25 ++
 rtl/shift_right_seq.sv | 109 ++++++++++
 tb/tb_shift_right_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shift_right_seq_if.sv
// Handshake bundle for shift_right_seq: operand/request side and result side.
// master = producer/consumer, slave = the shifter.
interface shift_right_seq_if #(
  parameter int SIZE = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE-1:0]         in;
  logic [$clog2(SIZE)-1:0] bit_shift;
  logic                    check;
  logic                    out_valid;
  logic                    out_ready;
  logic [SIZE-1:0]         out;
  logic                    range_err;

  modport master (
    output in_valid, in, bit_shift, check, out_ready,
    input  in_ready, out_valid, out, range_err
  );

  modport slave (
    input  in_valid, in, bit_shift, check, out_ready,
    output in_ready, out_valid, out, range_err
  );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential sign-magnitude right shifter, one bit per cycle, k = bit_shift - SIZE/2.
// Optional SHIFT_RIGHT_ROUND_EN: round-half-away-from-zero on the final shift.
module shift_right_seq #(
  parameter int SIZE = 32
) (
  input logic              clk,
  input logic              rst_n,
  shift_right_seq_if.slave bus
);
  localparam int CW = $clog2(SIZE);
  localparam int MW = SIZE - 1;
  localparam logic [CW-1:0] HALF = CW'(SIZE / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          sign;
  logic [MW-1:0] mag;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          range_err_q;
  logic [MW-1:0] shr;
  logic [MW-1:0] fin;
  logic          in_range;

  assign in_range = (bus.bit_shift >= HALF);

  // fin is the value written on the last shift; mag[0] is the bit leaving on that shift.
  always_comb begin
    shr = mag >> 1;
    fin = shr;
`ifdef SHIFT_RIGHT_ROUND_EN
    if (mag[0] && !(&shr)) fin = shr + MW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      mag         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            range_err_q <= !in_range;
            in_ready_q  <= 1'b0;
            if (!bus.check) begin
              sign        <= 1'b0;
              mag         <= '0;
              cnt         <= '0;
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else if (!in_range || bus.bit_shift == HALF) begin
              // k == 0: pass through, only the negative-zero fix applies
              sign        <= bus.in[SIZE-1] & (|bus.in[MW-1:0]);
              mag         <= bus.in[MW-1:0];
              cnt         <= '0;
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              sign  <= bus.in[SIZE-1];
              mag   <= bus.in[MW-1:0];
              cnt   <= bus.bit_shift - HALF;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            mag         <= fin;
            sign        <= sign & (|fin);
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            mag <= shr;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = {sign, mag};
  assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq (SIZE=32): directed cases, random ops
// against an arithmetic reference, backpressure, back-to-back and mid-op reset.
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  shift_right_seq_if #(.SIZE(32)) bus ();

  shift_right_seq #(.SIZE(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: {range_err, out} from plain arithmetic on the magnitude.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] bs, input logic c);
    logic [31:0] m;
    logic        re;
    int          k;
    re = (bs < 5'd16);
    k  = re ? 0 : int'(bs) - 16;
    if (!c) return {re, 32'h0};
    m = {1'b0, d[30:0]};
`ifdef SHIFT_RIGHT_ROUND_EN
    if (k > 0) begin
      m = (m + (32'd1 << (k - 1))) >> k;
      if (m > 32'h7FFF_FFFF) m = 32'h7FFF_FFFF;
    end
`else
    m = m >> k;
`endif
    return {re, (m != 0) ? d[31] : 1'b0, m[30:0]};
  endfunction

  function automatic int exp_lat(input logic [4:0] bs, input logic c);
    if (!c || bs <= 5'd16) return 1;
    return int'(bs) - 16 + 1;
  endfunction

  // Issue one operand and wait for out_valid; lat counts from the accept edge (1 = next cycle).
  task automatic op(input logic [31:0] d, input logic [4:0] bs, input logic c,
                    output int lat, output logic [31:0] o, output logic re);
    @(negedge clk);
    bus.in = d; bus.bit_shift = bs; bus.check = c; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in = $urandom; bus.bit_shift = 5'($urandom); bus.check = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    o  = bus.out;
    re = bus.range_err;
  endtask

  // Accept the pending result (called #1 after an edge).
  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=0", bus.out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.range_err !== 1'b0) begin bad++; $display("FAIL reset_range_err got=%b want=0", bus.range_err); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] din [5] = '{32'h0000_8000, 32'h8000_0030, 32'h0000_0003, 32'hFFFF_FFFF, 32'h8123_4567};
    logic [4:0]  bsv [5] = '{5'd20, 5'd17, 5'd17, 5'd20, 5'd10};
    logic        chk [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef SHIFT_RIGHT_ROUND_EN
    logic [31:0] want[5] = '{32'h0000_0800, 32'h8000_0018, 32'h0000_0002, 32'h0, 32'h8123_4567};
`else
    logic [31:0] want[5] = '{32'h0000_0800, 32'h8000_0018, 32'h0000_0001, 32'h0, 32'h8123_4567};
`endif
    logic        wre [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          wlat[5] = '{5, 2, 2, 1, 1};
    int lat; logic [31:0] o; logic re;
    for (int i = 0; i < 5; i++) begin
      op(din[i], bsv[i], chk[i], lat, o, re);
      total++; if (lat !== wlat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, wlat[i]); end
      total++; if (o !== want[i]) begin bad++; $display("FAIL dir%0d_out got=%h want=%h", i, o, want[i]); end
      total++; if (re !== wre[i]) begin bad++; $display("FAIL dir%0d_range_err got=%b want=%b", i, re, wre[i]); end
      drain();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL dir%0d_handshake out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] o; logic re; logic [31:0] d; logic [4:0] bs; logic c; logic [32:0] e;
    for (int i = 0; i < 60; i++) begin
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) d = {d[31], 31'($urandom_range(0, 40))};
      if ($urandom_range(0, 9) == 0) d = {d[31], 31'h7FFF_FFFF};
      bs = 5'($urandom_range(0, 31));
      c  = ($urandom_range(0, 7) != 0);
      e  = model(d, bs, c);
      op(d, bs, c, lat, o, re);
      total++; if (o !== e[31:0] || re !== e[32] || lat !== exp_lat(bs, c)) begin
        bad++;
        $display("FAIL rand%0d in=%h bs=%0d chk=%b got out=%h re=%b lat=%0d want out=%h re=%b lat=%0d",
                 i, d, bs, c, o, re, lat, e[31:0], e[32], exp_lat(bs, c));
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] o; logic re; logic [32:0] e;
    e = model(32'h8765_4321, 5'd19, 1'b1);
    op(32'h8765_4321, 5'd19, 1'b1, lat, o, re);
    bus.in = 32'h1234_5678; bus.bit_shift = 5'd16; bus.check = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bus.out !== e[31:0] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.range_err !== e[32]) begin
        bad++;
        $display("FAIL stall%0d out=%h vld=%b rdy=%b re=%b want out=%h vld=1 rdy=0 re=%b",
                 i, bus.out, bus.out_valid, bus.in_ready, bus.range_err, e[31:0], e[32]);
      end
    end
    bus.in_valid = 1'b0;
    drain();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] o; logic re; logic [31:0] d; logic [32:0] e;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      e = model(d, 5'(16 + i), 1'b1);
      op(d, 5'(16 + i), 1'b1, lat, o, re);
      bus.out_ready = 1'b1;
      total++; if (o !== e[31:0] || lat !== i + 1) begin
        bad++; $display("FAIL b2b%0d got out=%h lat=%0d want out=%h lat=%0d", i, o, lat, e[31:0], i + 1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in = 32'h7FFF_0000; bus.bit_shift = 5'd31; bus.check = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.range_err !== 1'b0) begin
      bad++; $display("FAIL midreset rdy=%b vld=%b out=%h re=%b want 1/0/0/0",
                      bus.in_ready, bus.out_valid, bus.out, bus.range_err);
    end
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_drop out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in = '0; bus.bit_shift = '0; bus.check = 1'b1; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
